// File: rtl/divider_pkg.sv
// ---------------------------------------------------------------------------
// divider_pkg
// Shared definitions for the sequential fractional divider:
//   - state_t          : controller states (IDLE / CALC / DONE)
//   - cnt_width()      : width of the iteration counter for a given Q_W/ROUND
//   - DIV_ZERO_FIRST   : flag priority, a zero divisor wins over overflow
// ---------------------------------------------------------------------------
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must be able to hold 0 .. Q_W+ROUND.
    function automatic int cnt_width(input int q_w, input int round);
        return $clog2(q_w + round + 1);
    endfunction

    // 0 >= 0 is true, so a zero divisor would otherwise also look like overflow.
    localparam bit DIV_ZERO_FIRST = 1'b1;

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One restoring shift-and-subtract iteration, purely combinational.
// Ports:
//   i_rem     [N_W:0]   current remainder (always < divisor)
//   i_divisor [N_W-1:0] divisor
//   o_rem     [N_W:0]   remainder after this iteration
//   o_ge      1         quotient bit produced by this iteration
// ---------------------------------------------------------------------------
module div_step #(
    parameter int N_W = 7
) (
    input  logic [N_W:0]   i_rem,
    input  logic [N_W-1:0] i_divisor,
    output logic [N_W:0]   o_rem,
    output logic           o_ge
);

    logic [N_W:0] w_rs;
    logic [N_W:0] w_div_ext;

    // i_rem < divisor < 2^N_W, so the shift never loses a set bit.
    assign w_rs      = i_rem << 1;
    assign w_div_ext = {1'b0, i_divisor};
    assign o_ge      = (w_rs >= w_div_ext);
    assign o_rem     = o_ge ? (w_rs - w_div_ext) : w_rs;

endmodule

// File: rtl/frac_divider_seq.sv
// ---------------------------------------------------------------------------
// frac_divider_seq
// Sequential fractional divider: frac_val = floor(dividend * 2^Q_W / divisor)
// as an unsigned Q0.Q_W value, one quotient bit per clock. With ROUND=1 one
// extra bit is computed and used to round half up, saturating at all ones.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   dividend, divisor   unsigned N_W-bit operands
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   frac_val            Q0.Q_W quotient, all ones on div_zero / ovf
//   div_zero            divisor was zero
//   ovf                 dividend >= divisor with a non-zero divisor
// ---------------------------------------------------------------------------
module frac_divider_seq #(
    parameter int N_W   = 7,
    parameter int Q_W   = 8,
    parameter int ROUND = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N_W-1:0] dividend,
    input  logic [N_W-1:0] divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [Q_W-1:0] frac_val,
    output logic           div_zero,
    output logic           ovf
);

    import divider_pkg::*;

    localparam int ITER  = Q_W + ROUND;
    localparam int CNT_W = cnt_width(Q_W, ROUND);

    state_t           r_state;
    logic [N_W-1:0]   r_divisor;
    logic [N_W:0]     r_rem;
    logic [ITER-1:0]  r_quo;
    logic [CNT_W-1:0] r_cnt;
    logic [Q_W-1:0]   r_frac;
    logic             r_div_zero;
    logic             r_ovf;

    logic [N_W:0]     w_rem_next;
    logic             w_ge;
    logic [ITER-1:0]  w_quo_next;
    logic [Q_W-1:0]   w_frac_final;
    logic             w_last;
    logic             w_in_zero;
    logic             w_in_ovf;

    div_step #(.N_W(N_W)) u_step (
        .i_rem     (r_rem),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_next),
        .o_ge      (w_ge)
    );

    assign w_quo_next = (r_quo << 1) | ITER'(w_ge);
    assign w_last     = (r_cnt == CNT_W'(ITER - 1));

    assign w_in_zero  = (divisor == '0);
    assign w_in_ovf   = (dividend >= divisor) && !(DIV_ZERO_FIRST && w_in_zero);

    // The extra LSB decides rounding; a carry out of the top means the
    // rounded value no longer fits and is clamped to all ones.
    if (ROUND != 0) begin : g_round
        logic [Q_W:0] w_sum;
        assign w_sum        = {1'b0, w_quo_next[Q_W:1]} + {{Q_W{1'b0}}, w_quo_next[0]};
        assign w_frac_final = w_sum[Q_W] ? '1 : w_sum[Q_W-1:0];
    end else begin : g_trunc
        assign w_frac_final = w_quo_next;
    end

    // NOTE: all state below updates with non-blocking assignments so every
    // register samples pre-edge values; the async reset also clears the
    // datapath registers so a discarded operation leaves no residue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_cnt      <= '0;
            r_frac     <= '0;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_divisor <= divisor;
                        r_rem     <= {1'b0, dividend};
                        r_quo     <= '0;
                        r_cnt     <= '0;
                        if (w_in_zero) begin
                            r_div_zero <= 1'b1;
                            r_frac     <= '1;
                            r_state    <= DONE;
                        end else if (w_in_ovf) begin
                            r_ovf   <= 1'b1;
                            r_frac  <= '1;
                            r_state <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_frac  <= w_frac_final;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_div_zero <= 1'b0;
                        r_ovf      <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign frac_val  = r_frac;
    assign div_zero  = r_div_zero;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_frac_divider_seq.sv
// ---------------------------------------------------------------------------
// tb_frac_divider_seq
// Two instances: dut0 (N_W=7, Q_W=8, truncate) and dut1 (N_W=8, Q_W=8,
// round half up). A ratio model predicts handshake timing and results from
// the arithmetic definition; directed vectors pin the model with literals.
// ---------------------------------------------------------------------------
module tb_frac_divider_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      iv   = '0;
    logic [1:0]      ordy = '0;
    logic [1:0][7:0] a    = '0;
    logic [1:0][7:0] b    = '0;
    logic [1:0]      ir, ov, dz, of;
    logic [1:0][7:0] fv;

    frac_divider_seq #(.N_W(7), .Q_W(8), .ROUND(0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(iv[0]), .in_ready(ir[0]),
        .dividend(a[0][6:0]), .divisor(b[0][6:0]),
        .out_valid(ov[0]), .out_ready(ordy[0]),
        .frac_val(fv[0]), .div_zero(dz[0]), .ovf(of[0])
    );

    frac_divider_seq #(.N_W(8), .Q_W(8), .ROUND(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(iv[1]), .in_ready(ir[1]),
        .dividend(a[1]), .divisor(b[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]),
        .frac_val(fv[1]), .div_zero(dz[1]), .ovf(of[1])
    );

    localparam int LAT  [2] = '{8, 9};
    localparam int MASK [2] = '{127, 255};
    localparam bit RND  [2] = '{1'b0, 1'b1};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int d, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at t=%0t", name, d, act, exp, $time);
        end
    endtask

    // Result from the definition: a*256/b, optionally rounded half up.
    function automatic int exp_frac(input int av, input int bv, input bit rnd);
        int v;
        if (bv == 0 || av >= bv) return 255;
        if (!rnd) return (av * 256) / bv;
        v = (av * 512 + bv) / (2 * bv);
        return (v > 255) ? 255 : v;
    endfunction

    // Model: one job in flight per DUT; result visible from edge m_vat on.
    int cyc = 0;
    bit m_busy [2];
    int m_vat  [2];
    int m_frac [2];
    int m_prev [2];
    bit m_dz   [2];
    bit m_ov   [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_busy[d] = 1'b0;
                m_prev[d] = 0;
            end
        end else begin
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (m_busy[d] && (cyc - 1) >= m_vat[d]) begin
                    if (ordy[d]) begin
                        m_busy[d] = 1'b0;
                        m_prev[d] = m_frac[d];
                    end
                end else if (!m_busy[d] && iv[d]) begin
                    int av, bv;
                    av = int'(a[d]) & MASK[d];
                    bv = int'(b[d]) & MASK[d];
                    m_busy[d] = 1'b1;
                    m_dz[d]   = (bv == 0);
                    m_ov[d]   = (bv != 0) && (av >= bv);
                    m_frac[d] = exp_frac(av, bv, RND[d]);
                    m_vat[d]  = cyc + ((m_dz[d] || m_ov[d]) ? 0 : LAT[d]);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            bit ev;
            ev = m_busy[d] && (cyc >= m_vat[d]);
            check("in_ready",  d, int'(ir[d]), m_busy[d] ? 0 : 1);
            check("out_valid", d, int'(ov[d]), ev ? 1 : 0);
            check("frac_val",  d, int'(fv[d]), ev ? m_frac[d] : m_prev[d]);
            check("div_zero",  d, int'(dz[d]), (ev && m_dz[d]) ? 1 : 0);
            check("ovf",       d, int'(of[d]), (ev && m_ov[d]) ? 1 : 0);
        end
    end

    // Call at a negedge; returns at a negedge after the result handshake.
    task automatic run_op(input int d, input int av, input int bv, input int ef,
                          input int edz, input int eov, input int eoff);
        int n;
        a[d] = 8'(av); b[d] = 8'(bv); iv[d] = 1'b1; ordy[d] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        iv[d] = 1'b0;
        n = 0;
        while (!ov[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("valid_edge_offset", d, n, eoff);
        check("lit_frac", d, int'(fv[d]), ef);
        check("lit_div_zero", d, int'(dz[d]), edz);
        check("lit_ovf", d, int'(of[d]), eov);
        ordy[d] = 1'b1;
        @(negedge clk);
        ordy[d] = 1'b0;
        check("in_ready_after_hs", d, int'(ir[d]), 1);
    endtask

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_in_ready",  d, int'(ir[d]), 1);
            check("rst_out_valid", d, int'(ov[d]), 0);
            check("rst_frac",      d, int'(fv[d]), 0);
            check("rst_flags",     d, int'({dz[d], of[d]}), 0);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // Truncating instance
        run_op(0, 1, 3, 8'h55, 0, 0, 8);
        run_op(0, 1, 2, 8'h80, 0, 0, 8);
        run_op(0, 0, 5, 8'h00, 0, 0, 8);
        run_op(0, 5, 0, 8'hFF, 1, 0, 0);
        run_op(0, 0, 0, 8'hFF, 1, 0, 0);
        run_op(0, 7, 7, 8'hFF, 0, 1, 0);
        run_op(0, 9, 4, 8'hFF, 0, 1, 0);
        run_op(0, 1, 127, 8'h02, 0, 0, 8);
        run_op(0, 126, 127, 8'hFD, 0, 0, 8);

        // Rounding instance
        run_op(1, 2, 3, 8'hAB, 0, 0, 9);
        run_op(1, 1, 3, 8'h55, 0, 0, 9);
        run_op(1, 254, 255, 8'hFF, 0, 0, 9);
        run_op(1, 5, 0, 8'hFF, 1, 0, 0);
        run_op(1, 200, 100, 8'hFF, 0, 1, 0);

        // Backpressure: result must hold and input pulses must be ignored.
        a[0] = 8'd1; b[0] = 8'd3; iv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        for (int i = 0; i < 12 && !ov[0]; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready",  0, int'(ir[0]), 0);
            check("bp_out_valid", 0, int'(ov[0]), 1);
            check("bp_frac",      0, int'(fv[0]), 8'h55);
            a[0] = 8'd1; b[0] = 8'd2; iv[0] = (i % 2 == 1);
            @(negedge clk);
        end
        iv[0] = 1'b0; ordy[0] = 1'b1;
        @(negedge clk);
        ordy[0] = 1'b0;
        check("bp_release_ready", 0, int'(ir[0]), 1);
        run_op(0, 1, 2, 8'h80, 0, 0, 8);

        // Reset during iteration 4 of 1/3.
        a[0] = 8'd1; b[0] = 8'd3; iv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_in_ready",  0, int'(ir[0]), 1);
        check("midrst_out_valid", 0, int'(ov[0]), 0);
        check("midrst_frac",      0, int'(fv[0]), 0);
        check("midrst_flags",     0, int'({dz[0], of[0]}), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        run_op(0, 1, 2, 8'h80, 0, 0, 8);

        // Back-to-back with both handshakes held high.
        iv = 2'b11; ordy = 2'b11;
        repeat (2500) begin
            for (int d = 0; d < 2; d++) begin
                int bv;
                bv = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, MASK[d]));
                b[d] = 8'(bv);
                a[d] = (bv > 0 && $urandom_range(0, 3) != 0) ? 8'($urandom_range(0, bv - 1))
                                                              : 8'($urandom_range(0, MASK[d]));
            end
            @(negedge clk);
        end

        // Random handshake pressure on both sides.
        repeat (2000) begin
            for (int d = 0; d < 2; d++) begin
                int bv;
                bv = int'($urandom_range(0, MASK[d]));
                b[d] = 8'(bv);
                a[d] = (bv > 0) ? 8'($urandom_range(0, bv - 1)) : 8'($urandom_range(0, MASK[d]));
                iv[d] = ($urandom_range(0, 2) != 0);
                ordy[d] = ($urandom_range(0, 2) != 0);
            end
            @(negedge clk);
        end
        iv = 2'b00; ordy = 2'b11;
        repeat (30) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
